// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and constants for the PS/2 scan-code decoder.
//   ps2_st_e : prefix-tracking FSM states
//   ps2_ev_t : decoded key event {ext, brk, code}
//   PFX_* / MOD_* / IGN_* : prefix, modifier and ignored scan codes
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_st_e;

  typedef struct packed {
    logic       ext;   // E0-prefixed key
    logic       brk;   // release (F0-prefixed)
    logic [7:0] code;
  } ps2_ev_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [7:0] MOD_LSHIFT = 8'h12;  // non-extended only
  localparam logic [7:0] MOD_RSHIFT = 8'h59;
  localparam logic [7:0] MOD_CTRL   = 8'h14;
  localparam logic [7:0] MOD_ALT    = 8'h11;

  // Error / self-test / ack bytes from the keyboard: never part of a key.
  localparam logic [7:0] IGN_ERR0 = 8'h00;
  localparam logic [7:0] IGN_ERR1 = 8'hFF;
  localparam logic [7:0] IGN_BAT  = 8'hAA;
  localparam logic [7:0] IGN_ACK  = 8'hFA;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == IGN_ERR0) || (b == IGN_ERR1) || (b == IGN_BAT) || (b == IGN_ACK);
  endfunction

  function automatic logic is_modifier(input logic ext, input logic [7:0] code);
    return ((code == MOD_LSHIFT) && !ext) || (code == MOD_RSHIFT) ||
           (code == MOD_CTRL) || (code == MOD_ALT);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo -- show-ahead event FIFO.
//   clk, rst      : clock, async active-high reset (empties the FIFO)
//   push_i/wdata_i: write request and event; ignored when full unless popping
//   pop_i         : remove head (ignored when empty)
//   rdata_o       : head event, valid whenever empty_o is low
//   full_o/empty_o: occupancy flags
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  ps2_ev_t wdata_i,
  input  logic    pop_i,
  output ps2_ev_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_q, rd_q;
  ps2_ev_t     mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  // When full, a same-cycle pop frees the head slot that the push overwrites.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_ONE;
      if (do_pop)  rd_q <= rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder -- turns a PS/2 set-2 scan byte stream into key events.
//   clk, rst            : clock, async active-high reset
//   in_data/in_valid    : byte offered by the PS/2 receiver
//   in_next             : one-cycle pop pulse back to the receiver
//   ev_valid/ev_ready   : show-ahead event FIFO handshake
//   ev_code/ev_ext/ev_break : head event fields
//   shift/ctrl/alt      : live modifier levels
//   key_cnt             : count of emitted non-modifier makes (wraps)
//   overflow/clr_ovf    : sticky FIFO-drop flag and its clear
// Byte accepted in cycle N -> stage-1 register in N+1 (modifiers, held key,
// counter and FIFO push all commit at the end of N+1) -> ev_valid in N+2.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_W           = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_next,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             shift,
  output logic             ctrl,
  output logic             alt,
  output logic [CNT_W-1:0] key_cnt,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // ---------------- byte intake ----------------
  // in_next is registered back so a receiver that needs a cycle to advance
  // never sees the same byte popped twice.
  logic nxt_q, accept;
  assign accept  = in_valid & ~nxt_q & ~rst;
  assign in_next = accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) nxt_q <= 1'b0;
    else     nxt_q <= accept;
  end

  // ---------------- prefix FSM ----------------
  ps2_st_e st_q, st_d;
  logic    ev_fire;
  ps2_ev_t ev_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d    = st_q;
    ev_fire = 1'b0;
    ev_new  = '0;
    if (accept) begin
      if (is_ignored(in_data)) begin
        st_d = ST_IDLE;
      end else if (in_data == PFX_EXT) begin
        case (st_q)
          ST_IDLE, ST_EXT: st_d = ST_EXT;
          default:         st_d = ST_EXT_BRK;
        endcase
      end else if (in_data == PFX_BRK) begin
        case (st_q)
          ST_IDLE, ST_BRK: st_d = ST_BRK;
          default:         st_d = ST_EXT_BRK;
        endcase
      end else begin
        ev_fire     = 1'b1;
        ev_new.ext  = (st_q == ST_EXT) || (st_q == ST_EXT_BRK);
        ev_new.brk  = (st_q == ST_BRK) || (st_q == ST_EXT_BRK);
        ev_new.code = in_data;
        st_d        = ST_IDLE;
      end
    end
  end

  // ---------------- stage 1: key state update ----------------
  logic             s1_vld_q;
  ps2_ev_t          s1_ev_q;
  logic [8:0]       held_q, held_d;   // {ext,code}; 0 means nothing held
  logic             lsh_q, lsh_d, rsh_q, rsh_d, ctl_q, ctl_d, alt_q, alt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [8:0]       s1_key;
  logic             s1_make, is_rep, emit, drop, fifo_full, fifo_empty, fifo_pop;
  ps2_ev_t          head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_ev_q  <= '0;
    end else begin
      s1_vld_q <= ev_fire;
      s1_ev_q  <= ev_new;
    end
  end

  assign s1_key   = {s1_ev_q.ext, s1_ev_q.code};
  assign s1_make  = ~s1_ev_q.brk;
  assign is_rep   = (SUPPRESS_REPEAT != 0) && s1_make && (s1_key == held_q);
  assign emit     = s1_vld_q & ~is_rep;
  assign fifo_pop = ev_valid & ev_ready;
  assign drop     = emit & fifo_full & ~fifo_pop;

  // State updates apply to every decoded event, including ones the FIFO drops.
  always_comb begin
    held_d = held_q;
    lsh_d  = lsh_q;
    rsh_d  = rsh_q;
    ctl_d  = ctl_q;
    alt_d  = alt_q;
    cnt_d  = cnt_q;
    if (s1_vld_q) begin
      if (s1_make)               held_d = s1_key;
      else if (held_q == s1_key) held_d = '0;
      if ((s1_ev_q.code == MOD_LSHIFT) && !s1_ev_q.ext) lsh_d = s1_make;
      if (s1_ev_q.code == MOD_RSHIFT) rsh_d = s1_make;
      if (s1_ev_q.code == MOD_CTRL)   ctl_d = s1_make;
      if (s1_ev_q.code == MOD_ALT)    alt_d = s1_make;
      if (emit && s1_make && !is_modifier(s1_ev_q.ext, s1_ev_q.code))
        cnt_d = cnt_q + CNT_ONE;
    end
  end

  // A drop in the same cycle as the clear wins so no loss goes unreported.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= '0;
      lsh_q  <= 1'b0;
      rsh_q  <= 1'b0;
      ctl_q  <= 1'b0;
      alt_q  <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      held_q <= held_d;
      lsh_q  <= lsh_d;
      rsh_q  <= rsh_d;
      ctl_q  <= ctl_d;
      alt_q  <= alt_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  // ---------------- event FIFO ----------------
  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (emit),
    .wdata_i (s1_ev_q),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_break = head.brk;
  assign shift    = lsh_q | rsh_q;
  assign ctrl     = ctl_q;
  assign alt      = alt_q;
  assign key_cnt  = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed vector table, hand-written corner
// sequences, and random byte streams checked against a prefix-flag model.
module tb_ps2_key_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_next;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [7:0] ev_code;
  logic       ev_ext, ev_break, shift, ctrl, alt, overflow;
  logic [7:0] key_cnt;
  logic       clr_ovf = 1'b0;

  ps2_key_decoder #(.FIFO_DEPTH(8), .CNT_W(8), .SUPPRESS_REPEAT(1)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_next(in_next),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
    .ev_break(ev_break), .shift(shift), .ctrl(ctrl), .alt(alt), .key_cnt(key_cnt),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int         nvec = 0, nerr = 0;
  logic [7:0] rx_q[$];
  logic [9:0] got[$];
  logic [9:0] exp_q[$];
  int         pulses = 0, b2b_err = 0, nbytes = 0;
  logic       prev_nxt = 1'b0, nxt_seen = 1'b0;
  logic       rand_ready = 1'b0, ready_fix = 1'b1;

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (in_next && prev_nxt) b2b_err++;
    prev_nxt = in_next;
    nxt_seen = in_next;
    if (in_next) pulses++;
    if (ev_valid && ev_ready) got.push_back({ev_ext, ev_break, ev_code});
  end

  // Receiver and consumer driver, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (nxt_seen && rx_q.size() > 0) void'(rx_q.pop_front());
    nxt_seen = 1'b0;
    in_valid = (rx_q.size() > 0);
    in_data  = in_valid ? rx_q[0] : 8'h00;
    ev_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
  end

  // ---------------- reference model ----------------
  logic       m_ext, m_brk, m_lsh, m_rsh, m_ctl, m_alt;
  logic [8:0] m_held;
  int         m_cnt;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_lsh = 0; m_rsh = 0; m_ctl = 0; m_alt = 0;
    m_held = '0; m_cnt = 0; exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] key;
    logic mk, rep, md;
    if (b == 8'h00 || b == 8'hFF || b == 8'hAA || b == 8'hFA) begin
      m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      key = {m_ext, b};
      mk  = !m_brk;
      rep = mk && (key == m_held);
      md  = (b == 8'h12 && !m_ext) || b == 8'h59 || b == 8'h14 || b == 8'h11;
      if (mk) m_held = key;
      else if (m_held == key) m_held = '0;
      if (b == 8'h12 && !m_ext) m_lsh = mk;
      if (b == 8'h59) m_rsh = mk;
      if (b == 8'h14) m_ctl = mk;
      if (b == 8'h11) m_alt = mk;
      if (!rep) begin
        exp_q.push_back({m_ext, m_brk, b});
        if (mk && !md) m_cnt++;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  // ---------------- helpers ----------------
  function automatic logic [9:0] mkev(input logic e, input logic r, input logic [7:0] c);
    return {e, r, c};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_q.push_back(b);
    nbytes++;
  endtask

  task automatic wait_done(input bit drain);
    int t = 0;
    while (rx_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    if (drain) begin
      rand_ready = 0; ready_fix = 1;
      while (ev_valid && t < 3000) begin @(negedge clk); t++; end
      repeat (2) @(negedge clk);
    end
    check("wait_timeout", 32'(t >= 3000), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; rand_ready = 0; ready_fix = 1;
    rx_q.delete();
    #2;
    check("rst_ev_valid", 32'(ev_valid), 0);
    check("rst_in_next", 32'(in_next), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    got.delete();
    model_reset();
    check("rst_state", {25'd0, shift, ctrl, alt, overflow, ev_valid, key_cnt == 8'd0, 1'b0}, 32'h2);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          n;
    logic [63:0] b;    // first byte in the top octet
    int          nev;
    logic [39:0] ev;   // first event in the top 10 bits
    logic        sh, ct, al;
    int          cnt;
  } vec_t;

  vec_t vt[9];
  logic [7:0] pool[14];

  initial begin
    vt[0] = '{3, 64'h1CF01C0000000000, 2, {mkev(0,0,8'h1C), mkev(0,1,8'h1C), 20'h0}, 0,0,0, 1};
    vt[1] = '{5, 64'hE075E0F075000000, 2, {mkev(1,0,8'h75), mkev(1,1,8'h75), 20'h0}, 0,0,0, 1};
    vt[2] = '{4, 64'h121C1C1C00000000, 2, {mkev(0,0,8'h12), mkev(0,0,8'h1C), 20'h0}, 1,0,0, 1};
    vt[3] = '{3, 64'hE014110000000000, 2, {mkev(1,0,8'h14), mkev(0,0,8'h11), 20'h0}, 0,1,1, 0};
    vt[4] = '{3, 64'h59E0120000000000, 2, {mkev(0,0,8'h59), mkev(1,0,8'h12), 20'h0}, 1,0,0, 1};
    vt[5] = '{6, 64'hE0F0FF1CAA230000, 2, {mkev(0,0,8'h1C), mkev(0,0,8'h23), 20'h0}, 0,0,0, 2};
    vt[6] = '{6, 64'hF0E075E0E0750000, 2, {mkev(1,1,8'h75), mkev(1,0,8'h75), 20'h0}, 0,0,0, 1};
    vt[7] = '{7, 64'h12F01214E0F01400, 4, {mkev(0,0,8'h12), mkev(0,1,8'h12),
                                           mkev(0,0,8'h14), mkev(1,1,8'h14)}, 0,0,0, 0};
    vt[8] = '{5, 64'h111CF01C1C000000, 4, {mkev(0,0,8'h11), mkev(0,0,8'h1C),
                                           mkev(0,1,8'h1C), mkev(0,0,8'h1C)}, 0,0,1, 2};
    pool = '{8'h1C, 8'h12, 8'h59, 8'h14, 8'h11, 8'hE0, 8'hF0,
             8'hF0, 8'h75, 8'h23, 8'hAA, 8'h00, 8'hE0, 8'h1C};

    // Directed table
    for (int v = 0; v < 9; v++) begin
      int p0;
      do_reset();
      p0 = pulses;
      for (int i = 0; i < vt[v].n; i++) push_byte(vt[v].b[63-8*i -: 8]);
      wait_done(1);
      check($sformatf("v%0d_nev", v), got.size(), vt[v].nev);
      for (int j = 0; j < vt[v].nev; j++)
        check($sformatf("v%0d_ev%0d", v, j), (j < got.size()) ? 32'(got[j]) : 32'hFFFF,
              32'(vt[v].ev[39-10*j -: 10]));
      check($sformatf("v%0d_mods", v), {29'd0, shift, ctrl, alt}, {29'd0, vt[v].sh, vt[v].ct, vt[v].al});
      check($sformatf("v%0d_cnt", v), 32'(key_cnt), vt[v].cnt);
      check($sformatf("v%0d_ovf", v), 32'(overflow), 0);
      check($sformatf("v%0d_pops", v), pulses - p0, vt[v].n);
    end

    // Overflow: nine makes with the consumer stalled
    begin
      logic [7:0] oc[9];
      oc = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
      do_reset();
      ready_fix = 0;
      for (int i = 0; i < 9; i++) push_byte(oc[i]);
      wait_done(0);
      check("ovf_set", 32'(overflow), 1);
      check("ovf_valid", 32'(ev_valid), 1);
      check("ovf_cnt", 32'(key_cnt), 9);
      check("ovf_none_popped", got.size(), 0);
      @(posedge clk); #1 clr_ovf = 1;
      @(posedge clk); #1 clr_ovf = 0;
      @(negedge clk);
      check("ovf_clr", 32'(overflow), 0);
      wait_done(1);
      check("ovf_held", got.size(), 8);
      for (int i = 0; i < 8; i++)
        check($sformatf("ovf_ev%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF, 32'(mkev(0,0,oc[i])));
    end

    // Prefix interrupted by reset
    do_reset();
    push_byte(8'hE0); push_byte(8'hF0);
    wait_done(1);
    check("rstpfx_no_ev", got.size(), 0);
    do_reset();
    push_byte(8'h1C);
    wait_done(1);
    check("rstpfx_nev", got.size(), 1);
    check("rstpfx_ev", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 32'(mkev(0,0,8'h1C)));

    // Random streams against the model, state carried across streams
    do_reset();
    for (int s = 0; s < 40; s++) begin
      int n = $urandom_range(1, 10);
      rand_ready = 1;
      for (int i = 0; i < n; i++) begin
        logic [7:0] b = pool[$urandom_range(0, 13)];
        model_byte(b);
        push_byte(b);
      end
      wait_done(1);
      check($sformatf("rnd%0d_nev", s), got.size(), exp_q.size());
      for (int j = 0; j < exp_q.size(); j++)
        check($sformatf("rnd%0d_ev%0d", s, j), (j < got.size()) ? 32'(got[j]) : 32'hFFFF, 32'(exp_q[j]));
      check($sformatf("rnd%0d_mods", s), {29'd0, shift, ctrl, alt},
            {29'd0, m_lsh | m_rsh, m_ctl, m_alt});
      check($sformatf("rnd%0d_cnt", s), 32'(key_cnt), 32'(m_cnt % 256));
      got.delete();
      exp_q.delete();
    end
    check("rnd_ovf", 32'(overflow), 0);

    check("in_next_spacing", b2b_err, 0);
    check("in_next_total", pulses, nbytes);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, giving event FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 8, giving the key counter width.
REQ-003 SHALL have parameter SUPPRESS_REPEAT, default 1; 1 drops typematic repeat makes.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-005 SHALL have port rst, input, 1, the asynchronous active-high reset.
REQ-006 SHALL have port in_data, input, 8, the scan byte from the PS/2 receiver.
REQ-007 SHALL have port in_valid, input, 1, meaning the receiver holds an unread byte.
REQ-008 SHALL have port in_next, output, 1, a single-cycle pop pulse to the receiver.
REQ-009 SHALL have port ev_valid, output, 1, meaning the FIFO head event is available.
REQ-010 SHALL have port ev_ready, input, 1, the consumer accept signal.
REQ-011 SHALL have port ev_code, output, 8, the head event scan code.
REQ-012 SHALL have port ev_ext, output, 1, the head event E0-prefix flag.
REQ-013 SHALL have port ev_break, output, 1, the head event release flag.
REQ-014 SHALL have port shift, ctrl and alt, each output, 1, the live modifier levels.
REQ-015 SHALL have port key_cnt, output, CNT_W, the count of counted key presses.
REQ-016 SHALL have port overflow, output, 1, a sticky event-drop flag.
REQ-017 SHALL have port clr_ovf, input, 1, which clears overflow.

Function
REQ-018 SHALL accept a byte in cycle N when in_valid=1 and in_next was 0 in cycle N-1, pulsing in_next in cycle N only (at most one pop every 2 cycles).
REQ-019 SHALL run FSM IDLE/EXT/BRK/EXT_BRK on accepted bytes: E0 moves IDLE->EXT; F0 moves IDLE->BRK and EXT->EXT_BRK; any other byte forms an event (ext = state in {EXT,EXT_BRK}, break = state in {BRK,EXT_BRK}) and returns to IDLE.
REQ-020 SHALL discard bytes 0x00, 0xFF, 0xAA and 0xFA in any state and return the FSM to IDLE without an event.
REQ-021 SHALL treat a second E0 in EXT as a no-op, and E0 in BRK as a move to EXT_BRK.
REQ-022 SHALL track shift as lshift(0x12, non-ext) OR rshift(0x59); ctrl as 0x14 with either ext value; alt as 0x11 with either ext value; a make sets and a break clears the corresponding bit.
REQ-023 SHALL keep a held {ext,code} register, set on a make and cleared on a break of the same {ext,code}.
REQ-024 SHALL, when SUPPRESS_REPEAT=1, not emit or count a make equal to the held register.
REQ-025 SHALL increment key_cnt by 1, wrapping modulo 2^CNT_W, on each emitted non-modifier make.
REQ-026 SHALL update modifiers in cycle N+1 and push the event in cycle N+1, so that ev_valid is asserted in cycle N+2 when the FIFO was empty.
REQ-027 SHALL present the FIFO in show-ahead form and pop it on any cycle with ev_valid & ev_ready.
REQ-028 SHALL, on a push to a full FIFO with no pop in the same cycle, drop the new event and set overflow; a push with a simultaneous pop when full SHALL succeed.
REQ-029 SHALL clear overflow on clr_ovf, except that a drop in the same cycle keeps it set.
REQ-030 SHALL always apply modifier, held-register and counter updates, even for a dropped event.

Reset
REQ-031 SHALL on rst set the FSM to IDLE and clear the FIFO, the held register, the modifiers, key_cnt, overflow and in_next; ev_valid SHALL be 0 during and after reset.
REQ-032 SHALL discard a prefix sequence interrupted by reset, with no partial event emitted.

Structure
REQ-033 SHALL place in package ps2_pkg the FSM state enum, the event struct {ext,break,code} and the prefix, modifier and ignore code constants.
REQ-034 SHALL implement the FIFO as sub-module ps2_evt_fifo (parametrised depth, show-ahead, full/empty), with decode logic in the parent.

Verification
REQ-035 SHALL cover: bytes 1C, F0 1C -> events {0,0,1C} then {0,1,1C}; key_cnt=1.
REQ-036 SHALL cover: E0 75, E0 F0 75 -> events {1,0,75} then {1,1,75}.
REQ-037 SHALL cover: 12, 1C, 1C, 1C with SUPPRESS_REPEAT=1 -> shift=1; one 1C make emitted; key_cnt=1.
REQ-038 SHALL cover: ev_ready=0 with 9 makes at FIFO_DEPTH=8 -> 8 held events, overflow=1, and clr_ovf clears it.
REQ-039 SHALL cover: E0 F0 then rst, then 1C -> single event {0,0,1C}.
REQ-040 SHALL cover: in_valid held high -> in_next pulses no more often than every 2nd cycle, and each byte is consumed exactly once.
